// File: rtl/sub_serial.sv
// Serial subtractor: d = a - b - bin, DIGIT bits per clock, LSB slice first, with borrow/zero/overflow flags.
// Latency N+1 cycles from accepted start to done pulse; start is ignored while busy, accepted in IDLE or DONE.
// No backpressure: done is a single-cycle pulse and results hold until the next done.
module sub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, part, part_nx;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             load;
  logic [DIGIT:0]   slice;
  int               base;

  // Current slice of the captured operands, merged into the partial result.
  always_comb begin
    base    = int'(cnt) * DIGIT;
    slice   = {1'b0, a_r[base +: DIGIT]} - {1'b0, b_r[base +: DIGIT]} - {{DIGIT{1'b0}}, brw};
    part_nx = part;
    part_nx[base +: DIGIT] = slice[DIGIT-1:0];
    last    = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      part <= '0;
      d    <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      a_r  <= a;
      b_r  <= b;
      brw  <= bin;
      cnt  <= '0;
      part <= '0;
    end else if (state == RUN) begin
      part <= part_nx;
      brw  <= slice[DIGIT];
      cnt  <= cnt + CW'(1);
      // Flags publish together with d on the edge that enters DONE.
      if (last) begin
        d    <= part_nx;
        bout <= slice[DIGIT];
        zero <= (part_nx == '0);
        ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (part_nx[WIDTH-1] != a_r[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Testbench for sub_serial (WIDTH=32, DIGIT=4): directed table, handshake corner cases, random ops vs arithmetic model.
module tb_sub_serial;
  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [31:0] a, b;
  logic        busy, done, bout, zero, ovf;
  logic [31:0] d;

  int checks = 0;
  int errors = 0;

  sub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned and signed integer arithmetic on 64-bit values.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                                output logic [31:0] md, output logic mbout,
                                output logic mzero, output logic movf);
    longint ua, ub, sa, sb, ud, sd, ib;
    ua = ma;
    ub = mb;
    ib = mbin;
    ud = ua - ub - ib;
    mbout = (ud < 0);
    md    = ud[31:0];
    mzero = (md == 32'd0);
    sa = $signed(ma);
    sb = $signed(mb);
    sd = sa - sb - ib;
    movf = (sd != longint'($signed(sd[31:0])));
  endfunction

  // Starts an op from an IDLE or DONE cycle and leaves the bench in the done cycle.
  // pulse_at > 0 raises start with junk operands during that RUN cycle.
  task automatic run_op(input string tag, input logic [31:0] oa, input logic [31:0] ob, input logic obin,
                        input logic [31:0] ed, input logic eb, input logic ez, input logic eo,
                        input int pulse_at);
    logic [31:0] hold_d;
    int cyc;
    hold_d = d;
    a = oa; b = ob; bin = obin; start = 1'b1;
    tick;
    start = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    cyc = 1;
    while (!done && cyc < 20) begin
      check({tag, " busy"}, busy, 1);
      check({tag, " d hold"}, d, hold_d);
      if (cyc == pulse_at) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end
      tick;
      start = 1'b0;
      cyc++;
    end
    check({tag, " latency"}, cyc, N + 1);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " d"}, d, ed);
    check({tag, " bout"}, bout, eb);
    check({tag, " zero"}, zero, ez);
    check({tag, " ovf"}, ovf, eo);
  endtask

  task automatic run_model(input string tag, input logic [31:0] oa, input logic [31:0] ob, input logic obin);
    logic [31:0] ed;
    logic eb, ez, eo;
    model(oa, ob, obin, ed, eb, ez, eo);
    run_op(tag, oa, ob, obin, ed, eb, ez, eo, 0);
  endtask

  initial begin
    int ndone;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd5,        32'd3,        1'b0, 32'd2,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd0,        32'd1,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h12345678, 32'h12345678, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h80000000, 32'd0,        1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'hFFFFFFFF, 32'd0,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick;
    tick;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset d", d, 0);
    check("reset bout", bout, 0);
    check("reset zero", zero, 0);
    check("reset ovf", ovf, 0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].d, vecs[i].bout, vecs[i].zero, vecs[i].ovf, 0);
      tick;
      check($sformatf("vec%0d idle done", i), done, 0);
      check($sformatf("vec%0d idle d", i), d, vecs[i].d);
    end

    // start mid-run is ignored; start in the done cycle chains a second op
    run_op("midstart", 32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0, 1'b0, 4);
    run_op("chained", 32'd50, 32'd8, 1'b0, 32'd42, 1'b0, 1'b0, 1'b0, 0);
    tick;

    // reset in cycle 4 of a run aborts it
    a = 32'd123; b = 32'd45; bin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort d", d, 0);
    check("abort flags", {bout, zero, ovf}, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick;
    end
    check("abort no done", ndone, 0);
    run_op("post reset", 32'd10, 32'd7, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 0);
    tick;

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(3, 0) == 0) ? ra : $urandom;
      run_model($sformatf("rand%0d", i), ra, rb, 1'($urandom));
      if ($urandom_range(1, 0) == 1) tick;
    end
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
